// File: rtl/multi_strand_led_driver_if.sv
// Pixel fetch channel between the multi-strand LED driver and its frame source.
//   master : driver side   - issues next_led_request/request_valid, takes colours
//   slave  : source side   - answers a request with colours and color_valid
// Colour buses pack 8 bits per strand; strand k uses bits [8k+7:8k].
interface multi_strand_led_driver_if #(
    parameter int NUM_STRANDS = 4,
    parameter int NUM_LEDS    = 64
);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [8*NUM_STRANDS-1:0] green_in;
    logic [8*NUM_STRANDS-1:0] red_in;
    logic [8*NUM_STRANDS-1:0] blue_in;
    logic                     color_valid;
    logic [IDX_W-1:0]         next_led_request;
    logic                     request_valid;

    modport master (
        output next_led_request,
        output request_valid,
        input  green_in,
        input  red_in,
        input  blue_in,
        input  color_valid
    );

    modport slave (
        input  next_led_request,
        input  request_valid,
        output green_in,
        output red_in,
        output blue_in,
        output color_valid
    );
endinterface

// File: rtl/multi_strand_led_driver.sv
// Multi-strand WS2812-style LED driver. One bit-timing engine drives
// NUM_STRANDS serial strands in lock-step. Pixels (all strands' GRB together)
// are fetched one slot at a time over the src channel and double-buffered so
// consecutive pixels stream without gaps; frames loop with a latch gap.
//
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   force_reset      synchronous abort back to the latch gap
//   strand_en        per-strand enable, sampled when the latch gap ends
//   src              pixel fetch channel (master side)
//   strand_out       serial data lines, registered
//   frame_done       pulse after the last bit of the last pixel
//   underflow        pulse when a stalled fetch times out
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_LATCH | lines low for RESET_CYCLES clocks between frames
// ST_FETCH | waiting for pixel 0 of the frame
// ST_SEND  | shifting the current pixel out, prefetching the next one
// ST_STALL | next pixel not delivered in time; lines low, timeout runs
module multi_strand_led_driver #(
    parameter int NUM_STRANDS  = 4,
    parameter int NUM_LEDS     = 64,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 30000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   force_reset,
    input  logic [NUM_STRANDS-1:0] strand_en,
    multi_strand_led_driver_if.master src,
    output logic [NUM_STRANDS-1:0] strand_out,
    output logic                   frame_done,
    output logic                   underflow
);
    localparam int BITS_PER_PIX = 24;
    localparam int BIT_W        = 5;
    localparam int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_MAX      = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [IDX_W-1:0]        pix_q, pix_d;
    logic [BITS_PER_PIX-1:0] sh_q   [NUM_STRANDS];
    logic [BITS_PER_PIX-1:0] sh_d   [NUM_STRANDS];
    logic [BITS_PER_PIX-1:0] nbuf_q [NUM_STRANDS];
    logic [BITS_PER_PIX-1:0] nbuf_d [NUM_STRANDS];
    logic                    full_q, full_d;
    logic [NUM_STRANDS-1:0]  mask_q, mask_d;
    logic                    req_q, req_d;
    logic [IDX_W-1:0]        req_idx_q, req_idx_d;
    logic [NUM_STRANDS-1:0]  out_q, out_d;
    logic                    done_q, done_d;
    logic                    uf_q, uf_d;

    logic [BITS_PER_PIX-1:0] in_pix [NUM_STRANDS];
    logic                    hs;

    always_comb begin
        for (int k = 0; k < NUM_STRANDS; k++) begin
            in_pix[k] = {src.green_in[8*k +: 8], src.red_in[8*k +: 8], src.blue_in[8*k +: 8]};
        end
    end

    assign hs = req_q & src.color_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        pix_d     = pix_q;
        sh_d      = sh_q;
        nbuf_d    = nbuf_q;
        full_d    = full_q;
        mask_d    = mask_q;
        req_d     = req_q;
        req_idx_d = req_idx_q;
        done_d    = 1'b0;
        uf_d      = 1'b0;
        out_d     = '0;

        case (state_q)
            ST_LATCH: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d   = ST_FETCH;
                    cnt_d     = '0;
                    mask_d    = strand_en;
                    pix_d     = '0;
                    req_d     = 1'b1;
                    req_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_FETCH: begin
                if (hs) begin
                    state_d   = ST_SEND;
                    sh_d      = in_pix;
                    cnt_d     = '0;
                    bit_d     = '0;
                    req_d     = (int'(pix_q) + 1 < NUM_LEDS);
                    req_idx_d = pix_q + IDX_W'(1);
                end
            end

            ST_SEND: begin
                if (hs) begin
                    nbuf_d = in_pix;
                    full_d = 1'b1;
                    req_d  = 1'b0;
                end
                if (cnt_q == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(BITS_PER_PIX - 1)) begin
                        if (pix_q == IDX_W'(NUM_LEDS - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_LATCH;
                            full_d  = 1'b0;
                            req_d   = 1'b0;
                        end else if (full_q || hs) begin
                            // a handshake on the very last cycle still counts as buffered
                            sh_d      = full_q ? nbuf_q : in_pix;
                            full_d    = 1'b0;
                            bit_d     = '0;
                            pix_d     = pix_q + IDX_W'(1);
                            req_d     = (int'(pix_q) + 2 < NUM_LEDS);
                            req_idx_d = pix_q + IDX_W'(1) + IDX_W'(1);
                        end else begin
                            // request stays outstanding; pix now names the awaited pixel
                            state_d = ST_STALL;
                            pix_d   = pix_q + IDX_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        for (int k = 0; k < NUM_STRANDS; k++) begin
                            sh_d[k] = {sh_q[k][BITS_PER_PIX-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STALL: begin
                if (hs) begin
                    state_d   = ST_SEND;
                    sh_d      = in_pix;
                    cnt_d     = '0;
                    bit_d     = '0;
                    req_d     = (int'(pix_q) + 1 < NUM_LEDS);
                    req_idx_d = pix_q + IDX_W'(1);
                end else if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    uf_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_LATCH;
                cnt_d   = '0;
            end
        endcase

        if (force_reset) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
            req_d   = 1'b0;
            full_d  = 1'b0;
            done_d  = 1'b0;
            uf_d    = 1'b0;
        end

        // lines are registered, so they are computed from the upcoming state
        for (int k = 0; k < NUM_STRANDS; k++) begin
            out_d[k] = (state_d == ST_SEND) && mask_d[k] &&
                       (cnt_d < (sh_d[k][BITS_PER_PIX-1] ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES)));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_LATCH;
            cnt_q     <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            full_q    <= 1'b0;
            mask_q    <= '0;
            req_q     <= 1'b0;
            req_idx_q <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            uf_q      <= 1'b0;
            for (int k = 0; k < NUM_STRANDS; k++) begin
                sh_q[k]   <= '0;
                nbuf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pix_q     <= pix_d;
            full_q    <= full_d;
            mask_q    <= mask_d;
            req_q     <= req_d;
            req_idx_q <= req_idx_d;
            out_q     <= out_d;
            done_q    <= done_d;
            uf_q      <= uf_d;
            for (int k = 0; k < NUM_STRANDS; k++) begin
                sh_q[k]   <= sh_d[k];
                nbuf_q[k] <= nbuf_d[k];
            end
        end
    end

    assign src.request_valid    = req_q;
    assign src.next_led_request = req_idx_q;
    assign strand_out           = out_q;
    assign frame_done           = done_q;
    assign underflow            = uf_q;
endmodule

// File: tb/tb_multi_strand_led_driver.sv
`timescale 1ns/1ps
module tb_multi_strand_led_driver;
    localparam int NS      = 2;
    localparam int NL      = 2;
    localparam int BC      = 10;
    localparam int T0H     = 3;
    localparam int T1H     = 7;
    localparam int RC      = 20;
    localparam int CW      = 8*NS;
    localparam int PIX_CYC = 24*BC;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          force_reset = 1'b0;
    logic [NS-1:0] strand_en = '0;
    logic [NS-1:0] strand_out;
    logic          frame_done;
    logic          underflow;

    multi_strand_led_driver_if #(.NUM_STRANDS(NS), .NUM_LEDS(NL)) src_if ();

    multi_strand_led_driver #(
        .NUM_STRANDS(NS), .NUM_LEDS(NL), .BIT_CYCLES(BC),
        .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RC)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .force_reset(force_reset),
        .strand_en(strand_en),
        .src(src_if),
        .strand_out(strand_out),
        .frame_done(frame_done),
        .underflow(underflow)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pol   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at cycle %0d: got %0d want %0d", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model: frame timeline in pixel time ----------------
    bit          m_gap, m_fetch, m_req, m_hn, m_done, m_uf;
    int          m_gcnt, m_t, m_stall, m_pix, m_ridx;
    logic [23:0] m_cur [NS];
    logic [23:0] m_nxt [NS];
    logic [NS-1:0] m_mask;

    task automatic mdl_reset();
        m_gap = 1; m_gcnt = 0; m_fetch = 0; m_t = -1; m_stall = -1; m_pix = 0;
        m_req = 0; m_ridx = 0; m_hn = 0; m_mask = '0; m_done = 0; m_uf = 0;
        for (int k = 0; k < NS; k++) begin
            m_cur[k] = '0;
            m_nxt[k] = '0;
        end
    endtask

    task automatic go_gap();
        m_gap = 1; m_gcnt = 0; m_fetch = 0; m_t = -1; m_stall = -1; m_req = 0; m_hn = 0;
    endtask

    task automatic begin_pixel(input logic [23:0] c [NS]);
        m_cur = c;
        m_t   = 0;
        m_hn  = 0;
        m_req = (m_pix + 1 < NL);
        m_ridx = m_pix + 1;
    endtask

    task automatic mdl_advance();
        logic [23:0] col [NS];
        bit hs;
        for (int k = 0; k < NS; k++)
            col[k] = {src_if.green_in[8*k +: 8], src_if.red_in[8*k +: 8], src_if.blue_in[8*k +: 8]};
        hs = m_req && src_if.color_valid;
        m_done = 0;
        m_uf   = 0;
        if (force_reset) begin
            go_gap();
        end else if (m_gap) begin
            if (m_gcnt == RC-1) begin
                m_gap = 0; m_fetch = 1; m_mask = strand_en; m_pix = 0; m_req = 1; m_ridx = 0;
            end else m_gcnt++;
        end else if (m_fetch) begin
            if (hs) begin
                m_fetch = 0;
                begin_pixel(col);
            end
        end else if (m_t >= 0) begin
            if (hs) begin
                m_nxt = col; m_hn = 1; m_req = 0;
            end
            if (m_t == PIX_CYC-1) begin
                if (m_pix == NL-1) begin
                    m_done = 1;
                    go_gap();
                end else if (m_hn) begin
                    m_pix++;
                    begin_pixel(m_nxt);
                end else begin
                    m_pix++; m_t = -1; m_stall = 0;
                end
            end else m_t++;
        end else if (m_stall >= 0) begin
            if (hs) begin
                m_stall = -1;
                begin_pixel(col);
            end else if (m_stall == RC-1) begin
                m_uf = 1;
                go_gap();
            end else m_stall++;
        end
    endtask

    function automatic logic [NS-1:0] m_lines();
        logic [NS-1:0] v;
        logic bv;
        v = '0;
        if (m_t >= 0) begin
            for (int k = 0; k < NS; k++) begin
                bv = m_cur[k][23 - m_t/BC];
                v[k] = m_mask[k] && ((m_t % BC) < (bv ? T1H : T0H));
            end
        end
        return v;
    endfunction

    // color_valid policies: 0 always, 1 random, 2 late pixel-1 delivery, 3 never pixel 1
    task automatic drive_cv();
        case (pol)
            0: src_if.color_valid = 1'b1;
            1: src_if.color_valid = 1'($urandom_range(0, 1));
            2: src_if.color_valid = !(m_req && m_ridx == 1) || (m_stall >= 4);
            default: src_if.color_valid = !(m_req && m_ridx == 1);
        endcase
    endtask

    task automatic step();
        drive_cv();
        mdl_advance();
        @(posedge clk_in);
        #1;
        cyc++;
        chk("lines", 32'(strand_out), 32'(m_lines()));
        chk("req_valid", 32'(src_if.request_valid), 32'(m_req));
        if (m_req) chk("req_idx", 32'(src_if.next_led_request), m_ridx);
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("underflow", 32'(underflow), 32'(m_uf));
    endtask

    task automatic set_directed_colours();
        src_if.green_in = 16'hFF80;
        src_if.red_in   = 16'hFF00;
        src_if.blue_in  = 16'hFF00;
    endtask

    initial begin : main
        int first_hi, fd, rq, ufc, s1, u1, h0, h1, n;
        bit ok;

        src_if.color_valid = 1'b0;
        set_directed_colours();
        strand_en = 2'b11;
        mdl_reset();

        #12;
        chk("rst_lines", 32'(strand_out), 0);
        chk("rst_req", 32'(src_if.request_valid), 0);
        chk("rst_idx", 32'(src_if.next_led_request), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_uf", 32'(underflow), 0);
        rst_in = 1'b0;

        // basic frame timing with a steady source
        pol = 0;
        first_hi = -1; fd = -1; rq = -1;
        for (int i = 0; i < 1200 && rq < 0; i++) begin
            step();
            if (first_hi < 0 && strand_out != '0) first_hi = cyc;
            if (fd < 0 && frame_done) fd = cyc;
            if (fd >= 0 && rq < 0 && cyc > fd && src_if.request_valid) rq = cyc;
        end
        chk("first_data", first_hi, RC + 1);
        chk("frame_len", fd - first_hi, NL*PIX_CYC);
        chk("latch_gap", rq - fd, RC);

        // pixel 1 arrives late: short stall, no underflow
        pol = 2;
        ufc = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (underflow) ufc++;
        end
        chk("late_no_uf", ufc, 0);

        // pixel 1 never arrives: timeout
        pol = 3;
        ufc = 0; s1 = -1; u1 = -1;
        for (int i = 0; i < 3000 && ufc < 2; i++) begin
            step();
            if (s1 < 0 && m_stall == 0) s1 = cyc;
            if (underflow) begin
                if (u1 < 0) u1 = cyc;
                ufc++;
            end
        end
        chk("uf_count", ufc, 2);
        chk("uf_delay", u1 - s1, RC);

        // enable mask sampled only at frame start
        pol = 0;
        strand_en = 2'b01;
        for (int i = 0; i < 2000 && !m_gap; i++) step();
        chk("wait_gap", 32'(m_gap), 1);
        for (int i = 0; i < 2000 && !m_fetch; i++) step();
        chk("wait_fetch", 32'(m_fetch), 1);
        strand_en = 2'b10;
        h0 = 0; h1 = 0; ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            step();
            h0 += int'(strand_out[0]);
            h1 += int'(strand_out[1]);
            if (frame_done) ok = 1;
        end
        chk("en_frame_end", 32'(ok), 1);
        chk("en_s1_high", h1, 0);
        chk("en_s0_high", h0, 2*(T1H + 23*T0H));

        // force_reset mid-pixel 1, single cycle and held
        strand_en = 2'b11;
        for (int i = 0; i < 2000 && !(m_pix == 1 && m_t == 55); i++) step();
        chk("wait_px1", 32'(m_t), 55);
        force_reset = 1'b1;
        step();
        force_reset = 1'b0;
        chk("frc_lines", 32'(strand_out), 0);
        chk("frc_req", 32'(src_if.request_valid), 0);
        n = 0;
        for (int i = 0; i < 200 && !src_if.request_valid; i++) begin
            step();
            n++;
        end
        chk("frc_gap", n, RC);
        for (int i = 0; i < 2000 && !(m_pix == 1 && m_t == 100); i++) step();
        chk("wait_px1b", 32'(m_t), 100);
        force_reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        force_reset = 1'b0;
        chk("frc_hold_lines", 32'(strand_out), 0);
        n = 0;
        for (int i = 0; i < 200 && !src_if.request_valid; i++) begin
            step();
            n++;
        end
        chk("frc_hold_gap", n, RC);

        // asynchronous reset mid-pixel
        for (int i = 0; i < 2000 && m_t != 1; i++) step();
        chk("wait_bit", 32'(m_t), 1);
        #3;
        rst_in = 1'b1;
        #1;
        chk("arst_lines", 32'(strand_out), 0);
        chk("arst_req", 32'(src_if.request_valid), 0);
        chk("arst_done", 32'(frame_done), 0);
        chk("arst_uf", 32'(underflow), 0);
        #2;
        rst_in = 1'b0;
        mdl_reset();

        // randomized traffic
        pol = 1;
        for (int i = 0; i < 8000; i++) begin
            src_if.green_in = CW'($urandom);
            src_if.red_in   = CW'($urandom);
            src_if.blue_in  = CW'($urandom);
            if ($urandom_range(0, 49) == 0) strand_en = NS'($urandom);
            force_reset = ($urandom_range(0, 499) == 0);
            step();
        end
        force_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_strand_led_driver.md
Name: multi_strand_led_driver

Overview:
- Parametrised successor to the single-strand WS2812-style driver: drives NUM_STRANDS serial LED strands in lock-step from one bit-timing engine.
- Fetches one pixel slot at a time (all strands' GRB colours together) from upstream via a request/valid handshake.
- Double-buffers the colours so each pixel streams gap-free, and loops frames continuously with a latch gap between frames.
- Adds per-strand enable, underflow detection and a frame_done strobe; sits between the frame source and the PMOD strand pins in top_level.

Parameters:
- NUM_STRANDS, 4, number of parallel strands / strand_out bits.
- NUM_LEDS, 64, pixels per strand per frame.
- BIT_CYCLES, 125, clocks per bit slot (1.25 us at 100 MHz).
- T0H_CYCLES, 40, high time for a 0 bit; must be < T1H_CYCLES.
- T1H_CYCLES, 80, high time for a 1 bit; must be < BIT_CYCLES.
- RESET_CYCLES, 30000, low latch gap between frames; also the stall timeout.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- force_reset  input  1  synchronous abort; restarts the frame through the latch gap.
- strand_en  input  NUM_STRANDS  per-strand enable; sampled at frame start.
- green_in  input  8*NUM_STRANDS  green per strand; strand k uses bits [8k+7:8k].
- red_in  input  8*NUM_STRANDS  red per strand, same packing.
- blue_in  input  8*NUM_STRANDS  blue per strand, same packing.
- color_valid  input  1  upstream colours valid for next_led_request.
- next_led_request  output  $clog2(NUM_LEDS)  pixel index requested.
- request_valid  output  1  request outstanding.
- strand_out  output  NUM_STRANDS  serial data lines.
- frame_done  output  1  one-cycle pulse when the last bit of pixel NUM_LEDS-1 completes.
- underflow  output  1  one-cycle pulse on stall timeout.

Behaviour:
- Reset, asynchronous on rst_in: all outputs 0; state LATCH; counters 0; buffer empty; enable mask 0.
- States: LATCH, FETCH, SEND, STALL.
- LATCH:
  - strand_out all 0 for exactly RESET_CYCLES clocks.
  - Then sample strand_en into the mask, set pixel index 0, enter FETCH.
- FETCH:
  - request_valid=1, next_led_request=0.
  - Handshake completes on a cycle with request_valid && color_valid.
  - On handshake, load shift registers with {G,R,B}, MSB first (24 bits), enter SEND.
  - The first high phase appears on strand_out the next cycle (1-cycle latency, outputs registered).
- SEND, per bit slot (counter 0..BIT_CYCLES-1):
  - Enabled strand k drives 1 while counter < TxH for its current bit, else 0.
  - Disabled strands are held 0 all frame.
  - All strands share slot boundaries.
- Prefetch:
  - On the first cycle of each pixel, if index+1 < NUM_LEDS, assert request_valid with next_led_request=index+1.
  - Handshake captures colours into the next-buffer and deasserts request_valid.
  - At most one outstanding request; color_valid while request_valid=0 is ignored.
- End of pixel (last cycle of bit 23):
  - If index = NUM_LEDS-1: pulse frame_done, enter LATCH.
  - Else if buffer full: load shift registers, increment index, continue SEND seamlessly (no gap cycle).
  - Else: enter STALL.
- STALL:
  - strand_out 0; request_valid stays 1; a stall counter increments.
  - On handshake, the next cycle resumes SEND bit 0 of that pixel.
  - If the counter reaches RESET_CYCLES first: pulse underflow, drop request_valid, enter LATCH; the frame restarts at pixel 0.
- Handshake and stall timeout in the same cycle: the handshake wins.
- force_reset:
  - Next cycle: strand_out 0, request_valid 0, buffer cleared, state LATCH with counter 0.
  - Held high: stays in LATCH with the counter held at 0.
  - Takes priority over every other event.
- strand_en changes mid-frame take effect only at the next LATCH exit.
- Index counter never wraps past NUM_LEDS-1; NUM_LEDS=1 is legal (no prefetch request).

Test Plan:
Bench parameters: NUM_STRANDS=2, NUM_LEDS=2, BIT_CYCLES=10, T0H=3, T1H=7, RESET_CYCLES=20.
- Release reset, color_valid=1, strand_en=2'b11, strand0 G=8'h80 else 0, strand1 all 8'hFF -> lines low 20 clocks. Then, one cycle after the handshake, bit 0 is strand0 high 7 / low 3 and strand1 high 7 / low 3. Strand0 bits 1..23 are 3-high; strand1 all 7-high.
- Steady color_valid=1 -> request for index 1 issued on the first cycle of pixel 0. Pixel 1 follows with zero gap. frame_done pulses once at 480 clocks after the first data cycle, then 20 low clocks, then a new request for index 0.
- Withhold color_valid for pixel 1 for 5 clocks past the end of pixel 0 -> lines low 5 clocks. Pixel 1 starts the cycle after the handshake; no underflow.
- Withhold color_valid for pixel 1 indefinitely -> underflow pulses 20 clocks into STALL; LATCH follows, then a request for index 0.
- strand_en=2'b01 -> strand_out[1] constant 0 all frame, strand_out[0] unchanged. Toggling strand_en mid-frame has no effect until the next frame.
- Assert force_reset mid-bit of pixel 1 -> next cycle all lines 0 and request_valid 0. Then 20 low clocks after deassertion, then a request for index 0. Separately, assert rst_in mid-pixel -> all outputs 0 immediately (asynchronous).
